// File: rtl/regarr_arbiter.sv
// regarr_arbiter: round-robin arbiter/sequencer that shares one 8x32
// register array between NREQ requesters. Each accepted command runs the
// fixed schedule IDLE -> CMD -> DATA -> WAIT, mirroring the array's own
// IDLE -> WRITE/READ -> DONE -> IDLE sequence, and ends in a one-cycle
// response pulse to the requester that owned it.
module regarr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ-1:0]   req_re1,
  input  logic [NREQ-1:0]   req_re2,
  input  logic [3*NREQ-1:0] req_waddr,
  input  logic [3*NREQ-1:0] req_raddr1,
  input  logic [3*NREQ-1:0] req_raddr2,
  input  logic [32*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [31:0]       rsp_rdata1,
  output logic [31:0]       rsp_rdata2,
  output logic              busy,
  output logic              ra_en,
  output logic              ra_we,
  output logic              ra_re1,
  output logic              ra_re2,
  output logic [2:0]        ra_waddr,
  output logic [2:0]        ra_raddr1,
  output logic [2:0]        ra_raddr2,
  output logic [31:0]       ra_wdata,
  input  logic [31:0]       ra_rdata1,
  input  logic [31:0]       ra_rdata2
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CMD  = 2'd1,
    ARB_DATA = 2'd2,
    ARB_WAIT = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [GW-1:0]   last_grant_r;
  logic [GW-1:0]   owner_r;
  logic [GW-1:0]   grant_s;
  logic            found_s;
  logic            handshake_s;
  logic            cmd_we_s;
  logic            cmd_re1_s;
  logic            cmd_re2_s;
  int              idx_s;

  // Round-robin search: first valid requester upward from last_grant+1, wrapping.
  always_comb begin
    grant_s = last_grant_r;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = (int'(last_grant_r) + k) % NREQ;
      if (!found_s && req_valid[idx_s]) begin
        found_s = 1'b1;
        grant_s = GW'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign handshake_s = (state_r == ARB_IDLE) && found_s;

  // Granted command fields; a write masks the read enables.
  always_comb begin
    cmd_we_s  = req_we[grant_s];
    cmd_re1_s = ~req_we[grant_s] & req_re1[grant_s];
    cmd_re2_s = ~req_we[grant_s] & req_re2[grant_s];
  end

  // Ready is offered only to the granted requester while idle.
  always_comb begin
    req_ready = '0;
    if (handshake_s) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: fixed four-step schedule once a command is accepted.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (handshake_s) begin
          state_nxt_s = ARB_CMD;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_CMD:  state_nxt_s = ARB_DATA;
      ARB_DATA: state_nxt_s = ARB_WAIT;
      ARB_WAIT: state_nxt_s = ARB_IDLE;
      default:  state_nxt_s = ARB_IDLE;
    endcase
  end

  // Remember the granted requester for fairness and for the response pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_r <= GW'(NREQ - 1);
      owner_r      <= '0;
    end else if (handshake_s) begin
      last_grant_r <= grant_s;
      owner_r      <= grant_s;
    end else begin
      last_grant_r <= last_grant_r;
      owner_r      <= owner_r;
    end
  end

  // Registered array controls: loaded at handshake, reads held through DATA.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ra_en     <= 1'b0;
      ra_we     <= 1'b0;
      ra_re1    <= 1'b0;
      ra_re2    <= 1'b0;
      ra_waddr  <= 3'd0;
      ra_raddr1 <= 3'd0;
      ra_raddr2 <= 3'd0;
      ra_wdata  <= 32'd0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (handshake_s) begin
            ra_en     <= cmd_we_s | cmd_re1_s | cmd_re2_s;
            ra_we     <= cmd_we_s;
            ra_re1    <= cmd_re1_s;
            ra_re2    <= cmd_re2_s;
            ra_waddr  <= req_waddr[int'(grant_s)*3 +: 3];
            ra_raddr1 <= req_raddr1[int'(grant_s)*3 +: 3];
            ra_raddr2 <= req_raddr2[int'(grant_s)*3 +: 3];
            ra_wdata  <= req_wdata[int'(grant_s)*32 +: 32];
          end else begin
            ra_en     <= 1'b0;
            ra_we     <= 1'b0;
            ra_re1    <= 1'b0;
            ra_re2    <= 1'b0;
            ra_waddr  <= 3'd0;
            ra_raddr1 <= 3'd0;
            ra_raddr2 <= 3'd0;
            ra_wdata  <= 32'd0;
          end
        end
        ARB_CMD: begin
          // The array reads during DATA, so read enables/addresses stay put.
          ra_en     <= 1'b0;
          ra_we     <= 1'b0;
          ra_waddr  <= 3'd0;
          ra_wdata  <= 32'd0;
        end
        default: begin
          ra_en     <= 1'b0;
          ra_we     <= 1'b0;
          ra_re1    <= 1'b0;
          ra_re2    <= 1'b0;
          ra_waddr  <= 3'd0;
          ra_raddr1 <= 3'd0;
          ra_raddr2 <= 3'd0;
          ra_wdata  <= 32'd0;
        end
      endcase
    end
  end

  // Capture read data at the end of DATA and pulse the owner's response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid  <= '0;
      rsp_rdata1 <= 32'd0;
      rsp_rdata2 <= 32'd0;
    end else if (state_r == ARB_DATA) begin
      rsp_valid          <= '0;
      rsp_valid[owner_r] <= 1'b1;
      rsp_rdata1         <= ra_re1 ? ra_rdata1 : 32'd0;
      rsp_rdata2         <= ra_re2 ? ra_rdata2 : 32'd0;
    end else begin
      rsp_valid  <= '0;
      rsp_rdata1 <= rsp_rdata1;
      rsp_rdata2 <= rsp_rdata2;
    end
  end

  assign busy = (state_r != ARB_IDLE);

endmodule

// File: tb/tb_regarr_arbiter.sv
// Directed bench for regarr_arbiter with NREQ=2 and a behavioural model of
// the 8x32 register array answering on ra_*.
module tb_regarr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, req_re1, req_re2, rsp_valid;
  logic [5:0]  req_waddr, req_raddr1, req_raddr2;
  logic [63:0] req_wdata;
  logic [31:0] rsp_rdata1, rsp_rdata2, ra_wdata, ra_rdata1, ra_rdata2;
  logic        busy, ra_en, ra_we, ra_re1, ra_re2;
  logic [2:0]  ra_waddr, ra_raddr1, ra_raddr2;

  int n_err = 0;
  int n_checks = 0;

  logic [31:0] mem [8];
  logic        arr_read;
  logic        overlap_seen = 1'b0;

  regarr_arbiter #(.NREQ(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_re1(req_re1), .req_re2(req_re2),
    .req_waddr(req_waddr), .req_raddr1(req_raddr1), .req_raddr2(req_raddr2),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata1(rsp_rdata1), .rsp_rdata2(rsp_rdata2),
    .busy(busy),
    .ra_en(ra_en), .ra_we(ra_we), .ra_re1(ra_re1), .ra_re2(ra_re2),
    .ra_waddr(ra_waddr), .ra_raddr1(ra_raddr1), .ra_raddr2(ra_raddr2),
    .ra_wdata(ra_wdata), .ra_rdata1(ra_rdata1), .ra_rdata2(ra_rdata2)
  );

  always #5 clk = ~clk;

  // Array model: write commits on the CMD edge, read data valid in the following cycle.
  always @(posedge clk) begin
    if (ra_en && ra_we) mem[ra_waddr] <= ra_wdata;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) arr_read <= 1'b0;
    else      arr_read <= ra_en && !ra_we && (ra_re1 || ra_re2);
  end

  assign ra_rdata1 = (arr_read && ra_re1) ? mem[ra_raddr1] : 32'hBAD0_0BAD;
  assign ra_rdata2 = (arr_read && ra_re2) ? mem[ra_raddr2] : 32'hBAD0_0BAD;

  always @(negedge clk) begin
    if (ra_we && (ra_re1 || ra_re2)) overlap_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cmd(input int i, input logic v, input logic we, input logic r1,
                         input logic r2, input logic [2:0] wa, input logic [2:0] a1,
                         input logic [2:0] a2, input logic [31:0] wd);
    req_valid[i]          = v;
    req_we[i]             = we;
    req_re1[i]            = r1;
    req_re2[i]            = r2;
    req_waddr[i*3 +: 3]   = wa;
    req_raddr1[i*3 +: 3]  = a1;
    req_raddr2[i*3 +: 3]  = a2;
    req_wdata[i*32 +: 32] = wd;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 2'b00; req_we = 2'b00; req_re1 = 2'b00; req_re2 = 2'b00;
    req_waddr = 6'd0; req_raddr1 = 6'd0; req_raddr2 = 6'd0; req_wdata = 64'd0;
    step; step;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ra_en", 32'(ra_en), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata1", rsp_rdata1, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    step;

    // req0 writes 0xDEADBEEF to reg 5
    set_cmd(0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 3'd0, 3'd0, 32'hDEADBEEF);
    #1;
    chk("wr_ready", 32'(req_ready), 32'd1);
    chk("wr_busy_T", 32'(busy), 32'd0);
    step;
    chk("wr_ra_en", 32'(ra_en), 32'd1);
    chk("wr_ra_we", 32'(ra_we), 32'd1);
    chk("wr_waddr", 32'(ra_waddr), 32'd5);
    chk("wr_wdata", ra_wdata, 32'hDEADBEEF);
    chk("wr_busy", 32'(busy), 32'd1);
    chk("wr_ready_cmd", 32'(req_ready), 32'd0);
    set_cmd(0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 32'd0);
    step;
    chk("wr_ra_en_data", 32'(ra_en), 32'd0);
    chk("wr_ra_we_data", 32'(ra_we), 32'd0);
    step;
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rdata1", rsp_rdata1, 32'd0);
    chk("wr_rdata2", rsp_rdata2, 32'd0);
    step;
    chk("wr_rsp_clear", 32'(rsp_valid), 32'd0);
    chk("wr_busy_end", 32'(busy), 32'd0);

    // req0 reads reg 5 on port 1
    set_cmd(0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd5, 3'd0, 32'd0);
    #1;
    chk("rd_ready", 32'(req_ready), 32'd1);
    step;
    chk("rd_ra_en", 32'(ra_en), 32'd1);
    chk("rd_ra_we", 32'(ra_we), 32'd0);
    chk("rd_ra_re1", 32'(ra_re1), 32'd1);
    chk("rd_ra_re2", 32'(ra_re2), 32'd0);
    chk("rd_raddr1", 32'(ra_raddr1), 32'd5);
    set_cmd(0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 32'd0);
    step; step;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rdata1", rsp_rdata1, 32'hDEADBEEF);
    chk("rd_rdata2", rsp_rdata2, 32'd0);
    step;

    // NOP from req1
    set_cmd(1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 32'd0);
    #1;
    chk("nop_ready", 32'(req_ready), 32'd2);
    step;
    chk("nop_ra_en_cmd", 32'(ra_en), 32'd0);
    chk("nop_busy", 32'(busy), 32'd1);
    set_cmd(1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 32'd0);
    step;
    chk("nop_ra_en_data", 32'(ra_en), 32'd0);
    step;
    chk("nop_rsp_valid", 32'(rsp_valid), 32'd2);
    chk("nop_rdata1", rsp_rdata1, 32'd0);
    chk("nop_rdata2", rsp_rdata2, 32'd0);
    step;

    // req0 read interrupted by reset during DATA
    set_cmd(0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd5, 3'd0, 32'd0);
    #1;
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    step;
    set_cmd(0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 32'd0);
    step;
    chk("rstmid_re1_held", 32'(ra_re1), 32'd1);
    rst = 1'b0;
    #1;
    chk("rstmid_re1", 32'(ra_re1), 32'd0);
    chk("rstmid_raddr1", 32'(ra_raddr1), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    step;
    chk("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    step;
    chk("rstmid_no_rsp2", 32'(rsp_valid), 32'd0);

    // Both requesters hold valid: grants alternate 0,1,0,1 every 4 cycles
    set_cmd(0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 3'd0, 32'h11);
    set_cmd(1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7, 3'd0, 3'd0, 32'h77);
    #1;
    chk("rr_grant0", 32'(req_ready), 32'd1);
    step;
    chk("rr_waddr0", 32'(ra_waddr), 32'd2);
    chk("rr_wdata0", ra_wdata, 32'h11);
    chk("rr_ready_busy", 32'(req_ready), 32'd0);
    step; step; step;
    chk("rr_grant1", 32'(req_ready), 32'd2);
    step;
    chk("rr_waddr1", 32'(ra_waddr), 32'd7);
    chk("rr_wdata1", ra_wdata, 32'h77);
    step; step; step;
    chk("rr_grant2", 32'(req_ready), 32'd1);
    step; step; step; step;
    chk("rr_grant3", 32'(req_ready), 32'd2);
    step;
    set_cmd(0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 32'd0);
    set_cmd(1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 32'd0);
    step; step; step;

    // Dual read by req1: reg 2 on port 1, reg 7 on port 2
    set_cmd(1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 3'd2, 3'd7, 32'd0);
    #1;
    chk("dual_ready", 32'(req_ready), 32'd2);
    step;
    chk("dual_ra_we", 32'(ra_we), 32'd0);
    chk("dual_re1", 32'(ra_re1), 32'd1);
    chk("dual_re2", 32'(ra_re2), 32'd1);
    chk("dual_raddr1", 32'(ra_raddr1), 32'd2);
    chk("dual_raddr2", 32'(ra_raddr2), 32'd7);
    set_cmd(1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 32'd0);
    step;
    chk("dual_ra_en_data", 32'(ra_en), 32'd0);
    chk("dual_ra_we_data", 32'(ra_we), 32'd0);
    chk("dual_re2_held", 32'(ra_re2), 32'd1);
    chk("dual_raddr2_held", 32'(ra_raddr2), 32'd7);
    step;
    chk("dual_rsp_valid", 32'(rsp_valid), 32'd2);
    chk("dual_rdata1", rsp_rdata1, 32'h11);
    chk("dual_rdata2", rsp_rdata2, 32'h77);
    step;

    // Back-to-back write then read of reg 3 (read via port 2 only)
    set_cmd(0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 3'd0, 3'd0, 32'hCAFE0003);
    #1;
    chk("b2b_wr_ready", 32'(req_ready), 32'd1);
    step;
    set_cmd(0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 32'd0);
    step; step; step;
    set_cmd(0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd3, 32'd0);
    #1;
    chk("b2b_rd_ready", 32'(req_ready), 32'd1);
    step;
    set_cmd(0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 32'd0);
    step; step;
    chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_rdata2", rsp_rdata2, 32'hCAFE0003);
    chk("b2b_rdata1", rsp_rdata1, 32'd0);
    step;
    chk("no_overlap", 32'(overlap_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
